// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control/data bundle for univ_shift_reg.
//   present  preset request, active-low, synchronous
//   en       mode enable; 0 holds the register
//   mode     operation select
//   d_in     parallel load data
//   ser_r    serial bit entering the LSB on shift-left
//   ser_l    serial bit entering the MSB on shift-right
//   q_out    register contents
//   q_bar    bitwise complement of q_out
//   so_out   registered shifted-out / carry / borrow bit
// master drives the controls; slave is the register itself.
interface univ_shift_reg_if #(
    parameter int unsigned WIDTH = 8
);
    logic             present;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d_in;
    logic             ser_r;
    logic             ser_l;
    logic [WIDTH-1:0] q_out;
    logic [WIDTH-1:0] q_bar;
    logic             so_out;

    modport master (
        output present, en, mode, d_in, ser_r, ser_l,
        input  q_out, q_bar, so_out
    );

    modport slave (
        input  present, en, mode, d_in, ser_r, ser_l,
        output q_out, q_bar, so_out
    );
endinterface

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal register. Holds, loads, shifts, rotates or counts
// up/down under a 3-bit mode select, with a registered shift-out/carry/borrow bit.
//   clk   rising-edge clock
//   clr   asynchronous clear, active-low; zeroes q_out and so_out immediately
//   bus   univ_shift_reg_if.slave: present, en, mode, d_in, ser_r, ser_l in;
//         q_out, q_bar, so_out out
// Priority at each edge: clr > present > en=0 (hold) > mode.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic            clk,
    input  logic            clr,
    univ_shift_reg_if.slave bus
);

    typedef enum logic [2:0] {
        ModeHold    = 3'b000,
        ModeLoad    = 3'b001,
        ModeShl     = 3'b010,
        ModeShr     = 3'b011,
        ModeRol     = 3'b100,
        ModeRor     = 3'b101,
        ModeCntUp   = 3'b110,
        ModeCntDown = 3'b111
    } mode_e;

    localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q, q_d;
    logic             so_q, so_d;
    logic [WIDTH:0]   sum_up;

    // Extra bit captures the carry out of the increment.
    assign sum_up = {1'b0, q_q} + {1'b0, One};

    always_comb begin
        q_d  = q_q;
        so_d = so_q;
        if (!bus.present) begin
            q_d  = '1;
            so_d = 1'b0;
        end else if (bus.en) begin
            // Each arm reads only the inputs it consumes, so X on unused inputs stays out.
            case (mode_e'(bus.mode))
                ModeHold: ;
                ModeLoad: q_d = bus.d_in;
                ModeShl: begin
                    q_d  = {q_q[WIDTH-2:0], bus.ser_r};
                    so_d = q_q[WIDTH-1];
                end
                ModeShr: begin
                    q_d  = {bus.ser_l, q_q[WIDTH-1:1]};
                    so_d = q_q[0];
                end
                ModeRol: begin
                    q_d  = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    so_d = q_q[WIDTH-1];
                end
                ModeRor: begin
                    q_d  = {q_q[0], q_q[WIDTH-1:1]};
                    so_d = q_q[0];
                end
                ModeCntUp: begin
                    q_d  = sum_up[WIDTH-1:0];
                    so_d = sum_up[WIDTH];
                end
                ModeCntDown: begin
                    q_d  = q_q - One;
                    so_d = (q_q == '0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_q  <= '0;
            so_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            so_q <= so_d;
        end
    end

    assign bus.q_out  = q_q;
    assign bus.q_bar  = ~q_q;
    assign bus.so_out = so_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    typedef struct {
        logic [7:0] q;
        logic       so;
    } exp_t;

    logic clk = 1'b0;
    logic clr;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    univ_shift_reg_if #(.WIDTH(8)) bus ();

    univ_shift_reg #(.WIDTH(8)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout q_out=%h so_out=%b required=finish", bus.q_out, bus.so_out);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pre, input logic e, input logic [2:0] md,
                         input logic [7:0] d, input logic sr, input logic sl);
        bus.present = pre;
        bus.en      = e;
        bus.mode    = md;
        bus.d_in    = d;
        bus.ser_r   = sr;
        bus.ser_l   = sl;
    endtask

    // Independent reference for the random phase.
    function automatic exp_t model(exp_t cur, logic pre, logic e, logic [2:0] md,
                                   logic [7:0] d, logic sr, logic sl);
        exp_t n = cur;
        if (!pre) begin
            n.q  = 8'hFF;
            n.so = 1'b0;
        end else if (e) begin
            case (md)
                3'd1: n.q = d;
                3'd2: begin n.q = {cur.q[6:0], sr};       n.so = cur.q[7]; end
                3'd3: begin n.q = {sl, cur.q[7:1]};       n.so = cur.q[0]; end
                3'd4: begin n.q = {cur.q[6:0], cur.q[7]}; n.so = cur.q[7]; end
                3'd5: begin n.q = {cur.q[0], cur.q[7:1]}; n.so = cur.q[0]; end
                3'd6: begin n.q = cur.q + 8'd1; n.so = (cur.q == 8'hFF); end
                3'd7: begin n.q = cur.q - 8'd1; n.so = (cur.q == 8'h00); end
                default: ;
            endcase
        end
        return n;
    endfunction

    task automatic test_reset();
        exp_t e;
        clr = 1'b1;
        drive(1'b0, 1'b1, 3'b001, 8'hA5, 1'b0, 1'b0);
        #2 clr = 1'b0;
        #1;
        checks++;
        if (bus.q_out !== 8'h00 || bus.q_bar !== 8'hFF || bus.so_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_async q=%h qb=%h so=%b required q=00 qb=ff so=0",
                     bus.q_out, bus.q_bar, bus.so_out);
        end
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{q: 8'h00, so: 1'b0});
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.q_out !== e.q || bus.q_bar !== ~e.q || bus.so_out !== e.so) begin
                failures++;
                $display("FAIL reset_held q=%h qb=%h so=%b required q=%h so=%b",
                         bus.q_out, bus.q_bar, bus.so_out, e.q, e.so);
            end
        end
        clr = 1'b1;
        drive(1'b1, 1'b1, 3'b001, 8'hA5, 1'b0, 1'b0);
        sb.push_back('{q: 8'hA5, so: 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (bus.q_out !== e.q || bus.q_bar !== ~e.q || bus.so_out !== e.so) begin
            failures++;
            $display("FAIL reset_release_load q=%h qb=%h so=%b required q=%h so=%b",
                     bus.q_out, bus.q_bar, bus.so_out, e.q, e.so);
        end
    endtask

    task automatic test_preset();
        exp_t e;
        logic [2:0] md[3]  = '{3'b001, 3'b000, 3'b110};
        logic       pre[3] = '{1'b1, 1'b0, 1'b1};
        logic       en[3]  = '{1'b1, 1'b0, 1'b0};
        exp_t       ex[3]  = '{'{8'h3C, 1'b0}, '{8'hFF, 1'b0}, '{8'hFF, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            drive(pre[i], en[i], md[i], 8'h3C, 1'b0, 1'b0);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.q_out !== e.q || bus.q_bar !== ~e.q || bus.so_out !== e.so) begin
                failures++;
                $display("FAIL preset_step%0d q=%h qb=%h so=%b required q=%h so=%b",
                         i, bus.q_out, bus.q_bar, bus.so_out, e.q, e.so);
            end
        end
    endtask

    task automatic test_shift();
        exp_t e;
        logic [2:0] md[4] = '{3'b001, 3'b010, 3'b010, 3'b011};
        exp_t       ex[4] = '{'{8'h81, 1'b0}, '{8'h03, 1'b1}, '{8'h07, 1'b0}, '{8'h03, 1'b1}};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, md[i], 8'h81, 1'b1, 1'b0);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.q_out !== e.q || bus.q_bar !== ~e.q || bus.so_out !== e.so) begin
                failures++;
                $display("FAIL shift_step%0d q=%h qb=%h so=%b required q=%h so=%b",
                         i, bus.q_out, bus.q_bar, bus.so_out, e.q, e.so);
            end
        end
    endtask

    task automatic test_rotate();
        exp_t e;
        logic [2:0] md[4] = '{3'b001, 3'b100, 3'b101, 3'b101};
        exp_t       ex[4] = '{'{8'h81, 1'b1}, '{8'h03, 1'b1}, '{8'h81, 1'b1}, '{8'hC0, 1'b1}};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, md[i], 8'h81, 1'b0, 1'b0);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.q_out !== e.q || bus.q_bar !== ~e.q || bus.so_out !== e.so) begin
                failures++;
                $display("FAIL rotate_step%0d q=%h qb=%h so=%b required q=%h so=%b",
                         i, bus.q_out, bus.q_bar, bus.so_out, e.q, e.so);
            end
        end
    endtask

    task automatic test_count_wrap();
        exp_t e;
        logic [2:0] md[6] = '{3'b001, 3'b110, 3'b110, 3'b110, 3'b111, 3'b111};
        exp_t       ex[6] = '{'{8'hFE, 1'b1}, '{8'hFF, 1'b0}, '{8'h00, 1'b1},
                              '{8'h01, 1'b0}, '{8'h00, 1'b0}, '{8'hFF, 1'b1}};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, md[i], 8'hFE, 1'b0, 1'b0);
            sb.push_back(ex[i]);
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.q_out !== e.q || bus.q_bar !== ~e.q || bus.so_out !== e.so) begin
                failures++;
                $display("FAIL count_step%0d q=%h qb=%h so=%b required q=%h so=%b",
                         i, bus.q_out, bus.q_bar, bus.so_out, e.q, e.so);
            end
        end
    endtask

    task automatic test_async_abort();
        exp_t e;
        drive(1'b1, 1'b1, 3'b001, 8'h04, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0);
        sb.push_back('{q: 8'h05, so: 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (bus.q_out !== e.q || bus.q_bar !== ~e.q || bus.so_out !== e.so) begin
            failures++;
            $display("FAIL abort_precount q=%h qb=%h so=%b required q=%h so=%b",
                     bus.q_out, bus.q_bar, bus.so_out, e.q, e.so);
        end
        #2 clr = 1'b0;
        #1;
        checks++;
        if (bus.q_out !== 8'h00 || bus.q_bar !== 8'hFF || bus.so_out !== 1'b0) begin
            failures++;
            $display("FAIL abort_immediate q=%h qb=%h so=%b required q=00 qb=ff so=0",
                     bus.q_out, bus.q_bar, bus.so_out);
        end
        tick();
        clr = 1'b1;
        bus.d_in  = 'x;
        bus.ser_l = 1'bx;
        bus.ser_r = 1'bx;
        sb.push_back('{q: 8'h01, so: 1'b0});
        tick();
        e = sb.pop_front();
        checks++;
        if (bus.q_out !== e.q || bus.q_bar !== ~e.q || bus.so_out !== e.so ||
            $isunknown({bus.q_out, bus.q_bar, bus.so_out})) begin
            failures++;
            $display("FAIL abort_resume_xfree q=%h qb=%h so=%b required q=%h so=%b",
                     bus.q_out, bus.q_bar, bus.so_out, e.q, e.so);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t cur = '{q: 8'h01, so: 1'b0};
        logic       pre, en, sr, sl;
        logic [2:0] md;
        logic [7:0] d;
        for (int i = 0; i < 60; i++) begin
            pre = ($urandom_range(0, 7) != 0);
            en  = ($urandom_range(0, 5) != 0);
            md  = 3'($urandom_range(0, 7));
            d   = 8'($urandom);
            sr  = 1'($urandom);
            sl  = 1'($urandom);
            drive(pre, en, md, d, sr, sl);
            cur = model(cur, pre, en, md, d, sr, sl);
            sb.push_back(cur);
            tick();
            e = sb.pop_front();
            checks++;
            if (bus.q_out !== e.q || bus.q_bar !== ~e.q || bus.so_out !== e.so) begin
                failures++;
                $display("FAIL random%0d mode=%b q=%h qb=%h so=%b required q=%h so=%b",
                         i, md, bus.q_out, bus.q_bar, bus.so_out, e.q, e.so);
            end
        end
    endtask

    initial begin
        test_reset();
        test_preset();
        test_shift();
        test_rotate();
        test_count_wrap();
        test_async_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
